// File: rtl/foc_pkg.sv
// Shared FOC control-loop definitions.
// State encoding and default datapath width.
package foc_pkg;

  localparam int FOC_WIDTH = 18;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SPD_START = 3'd1,
    ST_SPD_WAIT  = 3'd2,
    ST_CUR_START = 3'd3,
    ST_CUR_WAIT  = 3'd4,
    ST_UPDATE    = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

endpackage

// File: rtl/pi_loop_scheduler_if.sv
// PI controller bus: start/done handshakes,
// operands, results and mode controls.
interface pi_loop_scheduler_if
  import foc_pkg::*;
#(
  parameter int W = FOC_WIDTH
);

  logic         spd_start_o;
  logic         id_start_o;
  logic         iq_start_o;
  logic         spd_done_i;
  logic         id_done_i;
  logic         iq_done_i;
  logic [W-1:0] spd_y_i;
  logic [W-1:0] id_y_i;
  logic [W-1:0] iq_y_i;
  logic [W-1:0] spd_ref_o;
  logic [W-1:0] spd_act_o;
  logic [W-1:0] id_ref_o;
  logic [W-1:0] id_act_o;
  logic [W-1:0] iq_ref_o;
  logic [W-1:0] iq_act_o;
  logic         pi_en_o;
  logic         pi_clear_o;

  modport master (
    output spd_start_o, id_start_o, iq_start_o,
    output spd_ref_o, spd_act_o,
    output id_ref_o, id_act_o,
    output iq_ref_o, iq_act_o,
    output pi_en_o, pi_clear_o,
    input  spd_done_i, id_done_i, iq_done_i,
    input  spd_y_i, id_y_i, iq_y_i
  );

  modport slave (
    input  spd_start_o, id_start_o, iq_start_o,
    input  spd_ref_o, spd_act_o,
    input  id_ref_o, id_act_o,
    input  iq_ref_o, iq_act_o,
    input  pi_en_o, pi_clear_o,
    output spd_done_i, id_done_i, iq_done_i,
    output spd_y_i, id_y_i, iq_y_i
  );

endinterface

// File: rtl/pi_handshake_timer.sv
// Watchdog counter: cycles elapsed since a
// start strobe, with an expiry flag.
module pi_handshake_timer #(
  parameter int g_TIMEOUT = 64
) (
  input  logic sys_clk_i,
  input  logic reset_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [9:0] cnt;

  assign expired = (cnt == 10'(g_TIMEOUT - 1));

  // The start cycle itself counts as one elapsed cycle.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i)
      cnt <= '0;
    else if (clr)
      cnt <= 10'd1;
    else if (en && !expired)
      cnt <= cnt + 10'd1;
  end

endmodule

// File: rtl/pi_loop_scheduler.sv
// Sequences speed, d and q PI controllers once
// per PWM trigger and publishes vd/vq.
module pi_loop_scheduler
  import foc_pkg::*;
#(
  parameter int g_WIDTH     = FOC_WIDTH,
  parameter int g_SPEED_DIV = 10,
  parameter int g_TIMEOUT   = 64
) (
  input  logic               sys_clk_i,
  input  logic               reset_i,
  input  logic               trig_i,
  input  logic               loop_en_i,
  input  logic [g_WIDTH-1:0] speed_ref_i,
  input  logic [g_WIDTH-1:0] speed_act_i,
  input  logic [g_WIDTH-1:0] id_ref_i,
  input  logic [g_WIDTH-1:0] id_act_i,
  input  logic [g_WIDTH-1:0] iq_act_i,
  pi_loop_scheduler_if.master pi,
  output logic [g_WIDTH-1:0] vd_o,
  output logic [g_WIDTH-1:0] vq_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               overrun_o,
  output logic               timeout_o
);

  state_t             state_q, state_d;
  logic [7:0]         div_q;
  logic [g_WIDTH-1:0] spd_ref_q, spd_act_q;
  logic [g_WIDTH-1:0] id_ref_q, id_act_q;
  logic [g_WIDTH-1:0] iq_ref_q, iq_act_q;
  logic [g_WIDTH-1:0] id_hold_q, iq_hold_q;
  logic               d_flag_q, q_flag_q;
  logic               pi_en, accept, abort;
  logic               both_done;
  logic               tmr_clr, tmr_en, expired;

  assign pi_en     = loop_en_i & ~timeout_o;
  assign busy_o    = (state_q != ST_IDLE);
  assign accept    = (state_q == ST_IDLE) & trig_i & pi_en;
  assign abort     = busy_o & ~loop_en_i;
  assign both_done = (d_flag_q | pi.id_done_i)
                   & (q_flag_q | pi.iq_done_i);

  assign pi.pi_en_o   = pi_en;
  assign pi.spd_ref_o = spd_ref_q;
  assign pi.spd_act_o = spd_act_q;
  assign pi.id_ref_o  = id_ref_q;
  assign pi.id_act_o  = id_act_q;
  assign pi.iq_ref_o  = iq_ref_q;
  assign pi.iq_act_o  = iq_act_q;

  pi_handshake_timer #(
    .g_TIMEOUT (g_TIMEOUT)
  ) u_timer (
    .sys_clk_i (sys_clk_i),
    .reset_i   (reset_i),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .expired   (expired)
  );

  // Sequencer state register.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state and strobes; dropping enable aborts.
  always_comb begin
    state_d        = state_q;
    pi.spd_start_o = 1'b0;
    pi.id_start_o  = 1'b0;
    pi.iq_start_o  = 1'b0;
    pi.pi_clear_o  = 1'b0;
    valid_o        = 1'b0;
    tmr_clr        = 1'b0;
    tmr_en         = 1'b0;
    if (abort) begin
      state_d       = ST_IDLE;
      pi.pi_clear_o = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept)
            state_d = (div_q == 8'd0) ? ST_SPD_START
                                      : ST_CUR_START;
        end
        ST_SPD_START: begin
          pi.spd_start_o = 1'b1;
          tmr_clr        = 1'b1;
          state_d        = ST_SPD_WAIT;
        end
        ST_SPD_WAIT: begin
          tmr_en = 1'b1;
          if (pi.spd_done_i)  state_d = ST_CUR_START;
          else if (expired)   state_d = ST_FAULT;
        end
        ST_CUR_START: begin
          pi.id_start_o = 1'b1;
          pi.iq_start_o = 1'b1;
          tmr_clr       = 1'b1;
          state_d       = ST_CUR_WAIT;
        end
        ST_CUR_WAIT: begin
          tmr_en = 1'b1;
          if (both_done)      state_d = ST_UPDATE;
          else if (expired)   state_d = ST_FAULT;
        end
        ST_UPDATE: begin
          valid_o = 1'b1;
          state_d = ST_IDLE;
        end
        ST_FAULT: begin
          valid_o       = 1'b1;
          pi.pi_clear_o = 1'b1;
          state_d       = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Decimation counter; restarts when the loop is disabled.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i)
      div_q <= '0;
    else if (!loop_en_i)
      div_q <= '0;
    else if (accept)
      div_q <= (div_q == 8'(g_SPEED_DIV - 1)) ? 8'd0
                                              : div_q + 8'd1;
  end

  // Operand snapshot taken at trigger acceptance.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      spd_ref_q <= '0;
      spd_act_q <= '0;
      id_ref_q  <= '0;
      id_act_q  <= '0;
      iq_act_q  <= '0;
    end else if (accept) begin
      spd_ref_q <= speed_ref_i;
      spd_act_q <= speed_act_i;
      id_ref_q  <= id_ref_i;
      id_act_q  <= id_act_i;
      iq_act_q  <= iq_act_i;
    end
  end

  // Cascade: speed output becomes the q-current reference.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i)
      iq_ref_q <= '0;
    else if (state_q == ST_SPD_WAIT && pi.spd_done_i && !abort)
      iq_ref_q <= pi.spd_y_i;
  end

  // Sticky done flags and result holding registers.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      d_flag_q  <= 1'b0;
      q_flag_q  <= 1'b0;
      id_hold_q <= '0;
      iq_hold_q <= '0;
    end else if (state_q == ST_CUR_START) begin
      d_flag_q <= 1'b0;
      q_flag_q <= 1'b0;
    end else if (state_q == ST_CUR_WAIT) begin
      if (pi.id_done_i) begin
        d_flag_q  <= 1'b1;
        id_hold_q <= pi.id_y_i;
      end
      if (pi.iq_done_i) begin
        q_flag_q  <= 1'b1;
        iq_hold_q <= pi.iq_y_i;
      end
    end
  end

  // Publish results so vd/vq are valid alongside valid_o.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      vd_o <= '0;
      vq_o <= '0;
    end else if (state_d == ST_FAULT) begin
      vd_o <= '0;
      vq_o <= '0;
    end else if (state_q == ST_CUR_WAIT
                 && state_d == ST_UPDATE) begin
      vd_o <= pi.id_done_i ? pi.id_y_i : id_hold_q;
      vq_o <= pi.iq_done_i ? pi.iq_y_i : iq_hold_q;
    end
  end

  // Sticky watchdog flag and dropped-trigger pulse.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      timeout_o <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      overrun_o <= trig_i & busy_o & pi_en;
      if (!loop_en_i)
        timeout_o <= 1'b0;
      else if (state_q == ST_FAULT)
        timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pi_loop_scheduler.sv
// Directed bench for pi_loop_scheduler with
// behavioural PI models on the interface.
module tb_pi_loop_scheduler;

  localparam int W = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic         trig;
  logic         loop_en;
  logic [W-1:0] speed_ref, speed_act;
  logic [W-1:0] id_ref, id_act, iq_act;
  logic [W-1:0] vd, vq;
  logic         valid, busy, overrun, timeout;

  int checks = 0;
  int errors = 0;

  int       lat;
  bit       iq_hang;
  logic [W-1:0] spd_val, id_val, iq_val;

  int n_spd = 0;
  int n_valid = 0;
  int n_ovr = 0;

  pi_loop_scheduler_if #(.W(W)) pif ();

  pi_loop_scheduler #(
    .g_WIDTH     (W),
    .g_SPEED_DIV (3),
    .g_TIMEOUT   (64)
  ) dut (
    .sys_clk_i   (clk),
    .reset_i     (rst),
    .trig_i      (trig),
    .loop_en_i   (loop_en),
    .speed_ref_i (speed_ref),
    .speed_act_i (speed_act),
    .id_ref_i    (id_ref),
    .id_act_i    (id_act),
    .iq_act_i    (iq_act),
    .pi          (pif),
    .vd_o        (vd),
    .vq_o        (vq),
    .valid_o     (valid),
    .busy_o      (busy),
    .overrun_o   (overrun),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  int spd_cnt, id_cnt, iq_cnt;

  // PI models: done pulse some cycles after start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_cnt <= 0;
      id_cnt  <= 0;
      iq_cnt  <= 0;
      pif.spd_done_i <= 1'b0;
      pif.id_done_i  <= 1'b0;
      pif.iq_done_i  <= 1'b0;
      pif.spd_y_i    <= '0;
      pif.id_y_i     <= '0;
      pif.iq_y_i     <= '0;
    end else begin
      pif.spd_done_i <= 1'b0;
      pif.id_done_i  <= 1'b0;
      pif.iq_done_i  <= 1'b0;
      if (pif.spd_start_o) spd_cnt <= lat;
      else if (spd_cnt > 0) begin
        spd_cnt <= spd_cnt - 1;
        if (spd_cnt == 1) begin
          pif.spd_done_i <= 1'b1;
          pif.spd_y_i    <= spd_val;
        end
      end
      if (pif.id_start_o) id_cnt <= lat;
      else if (id_cnt > 0) begin
        id_cnt <= id_cnt - 1;
        if (id_cnt == 1) begin
          pif.id_done_i <= 1'b1;
          pif.id_y_i    <= id_val;
        end
      end
      if (pif.iq_start_o) iq_cnt <= lat;
      else if (iq_cnt > 0) begin
        iq_cnt <= iq_cnt - 1;
        if (iq_cnt == 1 && !iq_hang) begin
          pif.iq_done_i <= 1'b1;
          pif.iq_y_i    <= iq_val;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (pif.spd_start_o) n_spd++;
    if (valid)           n_valid++;
    if (overrun)         n_ovr++;
  end

  task automatic trig_pulse();
    @(negedge clk) trig = 1'b1;
    @(negedge clk) trig = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_valid got %b%b exp 00", busy, valid);
    end
    checks++;
    if (timeout !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b exp 00", timeout, overrun);
    end
    checks++;
    if (pif.iq_ref_o !== 18'h0 || vd !== 18'h0 || vq !== 18'h0) begin
      errors++;
      $display("FAIL reset_data iq_ref %h vd %h vq %h exp 0",
               pif.iq_ref_o, vd, vq);
    end
    checks++;
    if (pif.spd_start_o !== 1'b0 || pif.pi_clear_o !== 1'b0
        || pif.pi_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl start %b clear %b en %b exp 000",
               pif.spd_start_o, pif.pi_clear_o, pif.pi_en_o);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy got %b exp 0", busy);
    end
  endtask

  task automatic test_cascade();
    int pre, bv;
    lat = 5;
    spd_val = 18'h00400;
    id_val = 18'h00111;
    iq_val = 18'h00222;
    loop_en = 1'b1;
    bv = n_valid;
    for (int i = 0; i < 6; i++) begin
      pre = n_spd;
      speed_ref = 18'(100 + i);
      trig_pulse();
      repeat (39) @(negedge clk);
      checks++;
      if (n_spd - pre != ((i == 0 || i == 3) ? 1 : 0)) begin
        errors++;
        $display("FAIL cascade_spd_start trig %0d got %0d exp %0d",
                 i + 1, n_spd - pre, (i == 0 || i == 3) ? 1 : 0);
      end
      checks++;
      if (pif.spd_ref_o !== 18'(100 + i)) begin
        errors++;
        $display("FAIL cascade_operand got %h exp %h",
                 pif.spd_ref_o, 18'(100 + i));
      end
      if (i == 0) begin
        checks++;
        if (pif.iq_ref_o !== 18'h00400) begin
          errors++;
          $display("FAIL cascade_iq_ref got %h exp 00400",
                   pif.iq_ref_o);
        end
      end
    end
    checks++;
    if (n_valid - bv != 6) begin
      errors++;
      $display("FAIL cascade_valid_count got %0d exp 6", n_valid - bv);
    end
    checks++;
    if (vd !== 18'h00111 || vq !== 18'h00222) begin
      errors++;
      $display("FAIL cascade_vdq got %h/%h exp 00111/00222", vd, vq);
    end
  endtask

  task automatic test_same_cycle_done();
    bit found = 0;
    id_val = 18'h01234;
    iq_val = 18'h3FF00;
    trig_pulse();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (pif.id_done_i && pif.iq_done_i) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL same_cycle_done got none exp both dones");
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || vd !== 18'h01234 || vq !== 18'h3FF00) begin
      errors++;
      $display("FAIL same_cycle_update valid %b vd %h vq %h exp 1 01234 3ff00",
               valid, vd, vq);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_overrun();
    int bs, bo, bv;
    loop_en = 1'b0;
    repeat (2) @(negedge clk);
    loop_en = 1'b1;
    bs = n_spd;
    bo = n_ovr;
    bv = n_valid;
    trig_pulse();
    repeat (1) @(negedge clk);
    trig = 1'b1;
    @(negedge clk) trig = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (n_ovr - bo != 1) begin
      errors++;
      $display("FAIL overrun_pulse got %0d exp 1", n_ovr - bo);
    end
    checks++;
    if (n_spd - bs != 1 || n_valid - bv != 1) begin
      errors++;
      $display("FAIL overrun_single_run spd %0d valid %0d exp 1 1",
               n_spd - bs, n_valid - bv);
    end
    trig_pulse();
    repeat (30) @(negedge clk);
    checks++;
    if (n_spd - bs != 1 || n_valid - bv != 2) begin
      errors++;
      $display("FAIL overrun_div_once spd %0d valid %0d exp 1 2",
               n_spd - bs, n_valid - bv);
    end
  endtask

  task automatic test_timeout();
    bit found = 0;
    int n = 0;
    int bs, bv;
    loop_en = 1'b0;
    repeat (2) @(negedge clk);
    loop_en = 1'b1;
    iq_hang = 1'b1;
    trig_pulse();
    for (int k = 0; k < 60; k++) begin
      if (pif.iq_start_o) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL timeout_iq_start got none exp strobe");
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      n++;
      if (pif.pi_clear_o) break;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL timeout_latency got %0d exp 64", n);
    end
    checks++;
    if (valid !== 1'b1 || vd !== 18'h0 || vq !== 18'h0) begin
      errors++;
      $display("FAIL timeout_outputs valid %b vd %h vq %h exp 1 0 0",
               valid, vd, vq);
    end
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1 || pif.pi_en_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag got %b en %b exp 1 0",
               timeout, pif.pi_en_o);
    end
    bs = n_spd;
    bv = n_valid;
    trig_pulse();
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_spd != bs || n_valid != bv
        || timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ignore busy %b spd %0d valid %0d to %b exp 0 0 0 1",
               busy, n_spd - bs, n_valid - bv, timeout);
    end
    loop_en = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear got %b exp 0", timeout);
    end
    iq_hang = 1'b0;
    loop_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit found = 0;
    int bs, bv;
    lat = 20;
    trig_pulse();
    for (int k = 0; k < 10; k++) begin
      if (pif.spd_start_o) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL abort_spd_start got none exp strobe");
    end
    repeat (2) @(negedge clk);
    bv = n_valid;
    loop_en = 1'b0;
    #1;
    checks++;
    if (pif.pi_clear_o !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear got %b valid %b exp 1 0",
               pif.pi_clear_o, valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle busy got %b exp 0", busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (n_valid != bv) begin
      errors++;
      $display("FAIL abort_no_valid got %0d exp 0", n_valid - bv);
    end
    lat = 5;
    loop_en = 1'b1;
    bs = n_spd;
    trig_pulse();
    repeat (30) @(negedge clk);
    checks++;
    if (n_spd - bs != 1 || n_valid - bv != 1) begin
      errors++;
      $display("FAIL abort_reenable spd %0d valid %0d exp 1 1",
               n_spd - bs, n_valid - bv);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    trig_pulse();
    for (int k = 0; k < 10; k++) begin
      if (pif.iq_start_o) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (!found || busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre found %b busy %b exp 1 1", found, busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || pif.iq_ref_o !== 18'h0
        || vd !== 18'h0 || vq !== 18'h0) begin
      errors++;
      $display("FAIL areset_state busy %b iq_ref %h vd %h vq %h exp 0",
               busy, pif.iq_ref_o, vd, vq);
    end
    checks++;
    if (pif.iq_start_o !== 1'b0 || pif.id_start_o !== 1'b0
        || valid !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL areset_ctrl got %b%b%b%b exp 0000",
               pif.iq_start_o, pif.id_start_o, valid, timeout);
    end
    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    trig = 1'b0;
    loop_en = 1'b0;
    speed_ref = '0;
    speed_act = 18'h00010;
    id_ref = 18'h00020;
    id_act = 18'h00030;
    iq_act = 18'h00040;
    lat = 5;
    iq_hang = 1'b0;
    spd_val = '0;
    id_val = '0;
    iq_val = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_cascade();
    test_same_cycle_done();
    test_overrun();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
